// File: rtl/gshare_btb_if.sv
// Fetch-lookup and execute-update signal bundle for gshare_btb.
// master = core side (fetch/execute), slave = the predictor.
interface gshare_btb_if #(
  parameter int unsigned HIST_BITS = 4
);
  logic                 lookup_en;
  logic [31:0]          pcf;
  logic                 hit;
  logic                 predict_taken;
  logic [31:0]          pred_pc;
  logic [HIST_BITS-1:0] lookup_hist;

  logic                 upd_valid;
  logic [31:0]          upd_pc;
  logic [31:0]          upd_target;
  logic                 upd_taken;
  logic                 upd_mispredict;
  logic [HIST_BITS-1:0] upd_hist;

  modport master (
    output lookup_en, pcf, upd_valid, upd_pc, upd_target, upd_taken,
           upd_mispredict, upd_hist,
    input  hit, predict_taken, pred_pc, lookup_hist
  );

  modport slave (
    input  lookup_en, pcf, upd_valid, upd_pc, upd_target, upd_taken,
           upd_mispredict, upd_hist,
    output hit, predict_taken, pred_pc, lookup_hist
  );
endinterface

// File: rtl/gshare_btb.sv
// Gshare-indexed BTB with valid bits, saturating counters and history repair.
// Optional BTB_STATS_EN adds lookup/hit/mispredict counters.
module gshare_btb #(
  parameter int unsigned IDX_BITS  = 7,
  parameter int unsigned HIST_BITS = 4,
  parameter logic [1:0]  CTR_INIT  = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  gshare_btb_if.slave bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;

  logic                 valid_q  [DEPTH];
  logic                 valid_d  [DEPTH];
  logic [29:0]          tag_q    [DEPTH];
  logic [29:0]          tag_d    [DEPTH];
  logic [31:0]          target_q [DEPTH];
  logic [31:0]          target_d [DEPTH];
  logic [1:0]           ctr_q    [DEPTH];
  logic [1:0]           ctr_d    [DEPTH];
  logic [HIST_BITS-1:0] ghr_q;
  logic [HIST_BITS-1:0] ghr_d;

  logic [IDX_BITS-1:0]  look_idx;
  logic [IDX_BITS-1:0]  upd_idx;
  logic                 upd_hit;
  logic                 unused_pc_bits;

  function automatic logic [IDX_BITS-1:0] idx_f(input logic [31:0] pc,
                                                input logic [HIST_BITS-1:0] h);
    return pc[IDX_BITS+1:2] ^ IDX_BITS'(h);
  endfunction

  assign unused_pc_bits = &{1'b0, bus.upd_pc[1:0]};

  assign look_idx          = idx_f(bus.pcf, ghr_q);
  assign bus.hit           = valid_q[look_idx] && (tag_q[look_idx] == bus.pcf[31:2]);
  assign bus.predict_taken = bus.hit && ctr_q[look_idx][1];
  assign bus.pred_pc       = bus.predict_taken ? target_q[look_idx] : bus.pcf + 32'd4;
  assign bus.lookup_hist   = ghr_q;

  assign upd_idx = idx_f(bus.upd_pc, bus.upd_hist);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == bus.upd_pc[31:2]);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bus.upd_valid) begin
      if (upd_hit) begin
        if (bus.upd_taken) begin
          ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          target_d[upd_idx] = bus.upd_target;
        end else begin
          ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = bus.upd_pc[31:2];
        target_d[upd_idx] = bus.upd_target;
        ctr_d[upd_idx]    = CTR_INIT;
      end
    end
  end

  // Repair takes priority over the speculative shift from this cycle's lookup.
  always_comb begin
    ghr_d = ghr_q;
    if (bus.upd_valid && bus.upd_mispredict)
      ghr_d = HIST_BITS'({bus.upd_hist, bus.upd_taken});
    else if (bus.lookup_en && bus.hit)
      ghr_d = HIST_BITS'({ghr_q, bus.predict_taken});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '{default: 1'b0};
      ctr_q   <= '{default: 2'b01};
      ghr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
      ghr_q   <= ghr_d;
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q,     stat_lookups_d;
  logic [31:0] stat_hits_q,        stat_hits_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_lookups_d     = stat_lookups_q;
    stat_hits_d        = stat_hits_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (bus.lookup_en)
      stat_lookups_d = stat_lookups_q + 32'd1;
    if (bus.lookup_en && bus.hit)
      stat_hits_d = stat_hits_q + 32'd1;
    if (bus.upd_valid && bus.upd_mispredict)
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups_q     <= '0;
      stat_hits_q        <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_hits_q        <= stat_hits_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_hits        = stat_hits_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_gshare_btb.sv
// Scoreboard bench for gshare_btb: stimulus queues expected lookup results,
// a negedge monitor compares them whenever lookup_en is presented.
module tb_gshare_btb;

  localparam logic [31:0] PC_A  = 32'h0040_0010;
  localparam logic [31:0] PC_Z  = 32'h0000_1000;
  localparam logic [31:0] PC_Z3 = 32'h0000_2000;
  localparam logic [31:0] PC_B1 = 32'h0000_0040;
  localparam logic [31:0] PC_B2 = 32'h0000_0240;

  logic clk = 1'b0;
  logic reset;

  gshare_btb_if #(.HIST_BITS(4)) bus ();

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

  gshare_btb #(
    .IDX_BITS (7),
    .HIST_BITS(4),
    .CTR_INIT (2'b10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups    (stat_lookups),
    .stat_hits       (stat_hits),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        pt;
    logic [31:0] ppc;
    logic [3:0]  hist;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   next_id  = 0;

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s #%0d: got %h expected %h", name, id, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.lookup_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_lookup", -1, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("hit",           e.id, 32'(bus.hit),           32'(e.hit));
          check("predict_taken", e.id, 32'(bus.predict_taken), 32'(e.pt));
          check("pred_pc",       e.id, bus.pred_pc,            e.ppc);
          check("lookup_hist",   e.id, 32'(bus.lookup_hist),   32'(e.hist));
        end
      end
    end
  end

  task automatic step(input logic rst, input logic le, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic ut, input logic um, input logic [3:0] uh,
                      input logic eh, input logic ep, input logic [31:0] eppc,
                      input logic [3:0] ehist);
    exp_t e;
    reset              = rst;
    bus.lookup_en      = le;
    bus.pcf            = pc;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_target     = utgt;
    bus.upd_taken      = ut;
    bus.upd_mispredict = um;
    bus.upd_hist       = uh;
    if (le) begin
      e = '{hit: eh, pt: ep, ppc: eppc, hist: ehist, id: next_id};
      exp_q.push_back(e);
      next_id++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 4'd0);
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic ep,
                      input logic [31:0] eppc, input logic [3:0] ehist);
    step(1'b0, 1'b1, pc, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, eh, ep, eppc, ehist);
  endtask

  // Lookup plus a no-write mispredict on an unused PC, pinning history back to 0.
  task automatic look_restore(input logic [31:0] pc, input logic eh, input logic ep,
                              input logic [31:0] eppc, input logic [3:0] ehist);
    step(1'b0, 1'b1, pc, 1'b1, PC_Z, 32'd0, 1'b0, 1'b1, 4'd0, eh, ep, eppc, ehist);
  endtask

  task automatic upd(input logic [31:0] upc, input logic [31:0] utgt,
                     input logic ut, input logic um, input logic [3:0] uh);
    step(1'b0, 1'b0, 32'd0, 1'b1, upc, utgt, ut, um, uh, 1'b0, 1'b0, 32'd0, 4'd0);
  endtask

  task automatic train_a(input logic ut, input logic [31:0] utgt,
                         input logic ep, input logic [31:0] eppc);
    upd(PC_A, utgt, ut, 1'b0, 4'd0);
    look_restore(PC_A, 1'b1, ep, eppc, 4'd0);
  endtask

  initial begin : stimulus
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 4'd0);

    // Reset state, then allocation (same-cycle lookup still misses)
    look(PC_A, 1'b0, 1'b0, 32'h0040_0014, 4'd0);
    step(1'b0, 1'b1, PC_A, 1'b1, PC_A, 32'h0040_0100, 1'b1, 1'b0, 4'd0,
         1'b0, 1'b0, 32'h0040_0014, 4'd0);
    look_restore(PC_A, 1'b1, 1'b1, 32'h0040_0100, 4'd0);

    // Counter: 10 -> 11,11,11 then 10,01,00,00 then 01,10
    train_a(1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
    train_a(1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
    train_a(1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200);
    train_a(1'b0, 32'hDEAD_BEEC, 1'b1, 32'h0040_0200);
    train_a(1'b0, 32'hDEAD_BEEC, 1'b0, 32'h0040_0014);
    train_a(1'b0, 32'hDEAD_BEEC, 1'b0, 32'h0040_0014);
    train_a(1'b0, 32'hDEAD_BEEC, 1'b0, 32'h0040_0014);
    train_a(1'b1, 32'h0040_0200, 1'b0, 32'h0040_0014);
    train_a(1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200);

    // History: allocate A under ghr 0101, repair beats shift, then plain shift
    upd(PC_A, 32'h0040_0300, 1'b1, 1'b0, 4'b0101);
    upd(PC_Z, 32'h0000_0000, 1'b1, 1'b1, 4'b0010);
    step(1'b0, 1'b1, PC_A, 1'b1, PC_Z, 32'd0, 1'b0, 1'b1, 4'b0011,
         1'b1, 1'b1, 32'h0040_0300, 4'b0101);
    look(PC_Z3, 1'b0, 1'b0, 32'h0000_2004, 4'b0110);
    upd(PC_A, 32'h0040_0400, 1'b1, 1'b0, 4'b0110);
    look(PC_A, 1'b1, 1'b1, 32'h0040_0400, 4'b0110);
    look(PC_Z3, 1'b0, 1'b0, 32'h0000_2004, 4'b1101);
    upd(PC_Z, 32'd0, 1'b0, 1'b1, 4'd0);

    // Index aliasing / eviction, pcf+4 wrap
    upd(PC_B1, 32'h0000_1000, 1'b1, 1'b0, 4'd0);
    look_restore(PC_B1, 1'b1, 1'b1, 32'h0000_1000, 4'd0);
    upd(PC_B2, 32'h0000_2000, 1'b1, 1'b0, 4'd0);
    look(PC_B1, 1'b0, 1'b0, 32'h0000_0044, 4'd0);
    look_restore(PC_B2, 1'b1, 1'b1, 32'h0000_2000, 4'd0);
    look(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 4'd0);

    // Reset during an update: the update is discarded, everything misses
    step(1'b1, 1'b0, 32'd0, 1'b1, PC_B1, 32'h0000_3000, 1'b1, 1'b1, 4'd0,
         1'b0, 1'b0, 32'd0, 4'd0);
`ifdef BTB_STATS_EN
    check("stat_lookups",     -1, stat_lookups,     32'd0);
    check("stat_hits",        -1, stat_hits,        32'd0);
    check("stat_mispredicts", -1, stat_mispredicts, 32'd0);
`endif
    look(PC_B2, 1'b0, 1'b0, 32'h0000_0244, 4'd0);
    look(PC_A,  1'b0, 1'b0, 32'h0040_0014, 4'd0);
    look(PC_B1, 1'b0, 1'b0, 32'h0000_0044, 4'd0);

    idle();
    idle();
    check("queue_drained", -1, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
